// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states, default base address.
package dmem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store merge into an existing word and load extract with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    new_word = old_word;
    rdata    = '0;
    byte_v   = old_word[{offset, 3'b000} +: 8];
    half_v   = old_word[{offset[1], 4'b0000} +: 16];
    case (width)
      W_BYTE: begin
        new_word[{offset, 3'b000} +: 8] = wdata[7:0];
        rdata = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      // Halfword uses offset[1] only; a stray offset[0] is either ignored or flagged upstream.
      W_HALF: begin
        new_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      W_WORD: begin
        new_word = wdata;
        rdata    = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with LATENCY wait states over valid/ready request and response channels.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses with resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  width_q;

  logic        accept, commit, misalign, err;
  logic        cur_we, cur_uns;
  logic [31:0] cur_addr, cur_wdata, word_off, old_word, new_word, load_data;
  logic [1:0]  cur_width;
  logic [IW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == '0) state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With LATENCY=0 the access commits on the accept edge, so the live inputs stand in for the latch.
  assign cur_we    = (state == S_IDLE) ? req_we       : we_q;
  assign cur_uns   = (state == S_IDLE) ? req_unsigned : uns_q;
  assign cur_addr  = (state == S_IDLE) ? req_addr     : addr_q;
  assign cur_width = (state == S_IDLE) ? req_width    : width_q;
  assign cur_wdata = (state == S_IDLE) ? req_wdata    : wdata_q;

  assign commit   = (state_next == S_RESP) && (state != S_RESP);
  assign word_off = (cur_addr - BASE_ADDR) >> 2;
  assign idx      = word_off[IW-1:0];
  assign old_word = mem[idx];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = ((cur_width == W_HALF) && cur_addr[0]) ||
                    ((cur_width == W_WORD) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err = (cur_addr < BASE_ADDR) || (word_off >= DEPTH_WORDS) ||
               (cur_width == W_RSVD) || misalign;

  dmem_lane_align u_align (
    .old_word    (old_word),
    .wdata       (cur_wdata),
    .width       (cur_width),
    .offset      (cur_addr[1:0]),
    .is_unsigned (cur_uns),
    .new_word    (new_word),
    .rdata       (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      width_q    <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        width_q <= req_width;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_err   <= err;
        resp_rdata <= (err || cur_we) ? '0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && cur_we && !err) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic vs a byte-level model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_width = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [int unsigned];

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Reference: memory as bytes-in-words, loads assembled byte by byte, sign via subtracting 2^bits.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [1:0] width,
                            input logic uns, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
    int unsigned idx, nb, lane0;
    logic [31:0] word;
    logic [63:0] val;
    err = (addr < BASE) || ((addr - BASE) / 4 >= DEPTH) || (width == 2'd3);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((width == 2'd1 && addr % 2 != 0) || (width == 2'd2 && addr % 4 != 0)) err = 1'b1;
`endif
    rdata = '0;
    if (err) return;
    idx   = (addr - BASE) / 4;
    nb    = 1 << width;
    lane0 = (width == 2'd0) ? addr % 4 : (width == 2'd1) ? ((addr % 4) / 2) * 2 : 0;
    word  = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (we) begin
      for (int unsigned k = 0; k < nb; k++) word[8*(lane0+k) +: 8] = wdata[8*k +: 8];
      ref_mem[idx] = word;
    end else begin
      val = '0;
      for (int unsigned k = 0; k < nb; k++) val = val + (64'(word[8*(lane0+k) +: 8]) << (8*k));
      if (!uns && val[8*nb-1]) val = val - (64'd1 << (8*nb));
      rdata = val[31:0];
    end
  endtask

  // Full transaction: request, wait for response, optional stall, handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] width,
                     input logic uns, input logic [31:0] wdata, input int stall,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic rdy_after);
    int n = 0;
    rdata = '0; err = 1'b0; lat = 0; rdy_after = 1'b0;
    req_we = we; req_addr = addr; req_width = width; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      total++; bad++; $display("FAIL req_timeout req_ready=%0b want=1", req_ready);
      req_valid = 1'b0; return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = $urandom; req_addr = $urandom; req_width = $urandom; req_wdata = $urandom;
    req_unsigned = $urandom;
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin
      total++; bad++; $display("FAIL resp_timeout resp_valid=%0b want=1", resp_valid); return;
    end
    repeat (stall) begin @(posedge clk); #1; end
    rdata = resp_rdata; err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    rdy_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0b want=0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", resp_err); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0b want=1", req_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd; logic er, eer, ra; int lat;
    txn(1'b1, 32'h1001_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, rd, er, lat, ra);
    ref_access(1'b1, 32'h1001_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, erd, eer);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL sw_resp got=%h/%0b want=0/0", rd, er); end
    total++; if (ra !== 1'b1) begin bad++; $display("FAIL back_to_back got=%0b want=1", ra); end
    txn(1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL lw_latency got=%0d want=%0d", lat, LAT + 1); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_err got=%0b want=0", er); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, erd; logic er, eer, ra; int lat;
    txn(1'b1, 32'h1001_0005, 2'd0, 1'b0, 32'h1234_5680, 0, rd, er, lat, ra);
    ref_access(1'b1, 32'h1001_0005, 2'd0, 1'b0, 32'h1234_5680, erd, eer);
    txn(1'b0, 32'h1001_0005, 2'd0, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb got=%h want=ffffff80", rd); end
    txn(1'b0, 32'h1001_0005, 2'd0, 1'b1, 32'h0, 0, rd, er, lat, ra);
    total++; if (rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h want=00000080", rd); end
    txn(1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (rd !== 32'hDEAD_80EF) begin bad++; $display("FAIL lw_after_sb got=%h want=dead80ef", rd); end
  endtask

  task automatic test_stall();
    logic [31:0] first; int n = 0;
    req_we = 1'b0; req_addr = 32'h1001_0004; req_width = 2'd2; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h1001_0008; req_we = 1'b1;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL stall_resp_timeout got=%0b want=1", resp_valid); end
    first = resp_rdata;
    total++; if (first !== 32'hDEAD_80EF) begin bad++; $display("FAIL stall_data got=%h want=dead80ef", first); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold valid=%0b rdata=%h ready=%0b want 1/%h/0", resp_valid, resp_rdata, req_ready, first);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b want=0", resp_valid); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, ra; int lat;
    txn(1'b0, 32'h1000_FFFC, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_below got=%h/%0b want=0/1", rd, er); end
    txn(1'b0, BASE + 4 * DEPTH, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_above got=%h/%0b want=0/1", rd, er); end
    txn(1'b0, BASE + 4 * DEPTH - 4, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL last_word_err got=%0b want=0", er); end
    txn(1'b1, 32'h1001_0004, 2'd3, 1'b0, 32'h5555_5555, 0, rd, er, lat, ra);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_rsvd got=%h/%0b want=0/1", rd, er); end
    txn(1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (rd !== 32'hDEAD_80EF) begin bad++; $display("FAIL rsvd_no_write got=%h want=dead80ef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd; logic er, eer, ra; int lat;
    txn(1'b1, 32'h1001_0000, 2'd2, 1'b0, 32'hCAFE_F00D, 0, rd, er, lat, ra);
    ref_access(1'b1, 32'h1001_0000, 2'd2, 1'b0, 32'hCAFE_F00D, erd, eer);
    txn(1'b0, 32'h1001_0003, 2'd1, 1'b0, 32'h0, 0, rd, er, lat, ra);
`ifdef DMEM_MISALIGN_ERR_EN
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lh_misalign got=%h/%0b want=0/1", rd, er); end
`else
    total++; if (er !== 1'b0 || rd !== 32'hFFFF_CAFE) begin bad++; $display("FAIL lh_misalign got=%h/%0b want=ffffcafe/0", rd, er); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer, ra; int lat;
    txn(1'b1, 32'h1001_0008, 2'd2, 1'b0, 32'h1111_2222, 0, rd, er, lat, ra);
    ref_access(1'b1, 32'h1001_0008, 2'd2, 1'b0, 32'h1111_2222, erd, eer);
    txn(1'b0, 32'h1001_0008, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    req_we = 1'b1; req_addr = 32'h1001_0008; req_width = 2'd2; req_wdata = 32'h9999_AAAA;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h want=0", resp_rdata); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%0b want=1", req_ready); end
    txn(1'b0, 32'h1001_0008, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ra);
    total++; if (rd !== 32'h1111_2222) begin bad++; $display("FAIL midrst_old_data got=%h want=11112222", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, ra, we, uns; logic [1:0] w; int lat;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      txn(1'b1, BASE + 4 * i, 2'd2, 1'b0, wd, 0, rd, er, lat, ra);
      ref_access(1'b1, BASE + 4 * i, 2'd2, 1'b0, wd, erd, eer);
    end
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE - 32'($urandom_range(1, 8));
        1:       addr = BASE + 4 * DEPTH + 32'($urandom_range(0, 7));
        default: addr = BASE + 32'($urandom_range(0, 63));
      endcase
      we = $urandom; w = $urandom; uns = $urandom; wd = $urandom;
      ref_access(we, addr, w, uns, wd, erd, eer);
      txn(we, addr, w, uns, wd, $urandom_range(0, 3), rd, er, lat, ra);
      total++;
      if (rd !== erd || er !== eer || lat !== LAT + 1 || ra !== 1'b1) begin
        bad++;
        $display("FAIL rand_txn we=%0b addr=%h w=%0d u=%0b got=%h/%0b/%0d/%0b want=%h/%0b/%0d/1",
                 we, addr, w, uns, rd, er, lat, ra, erd, eer, LAT + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_stall();
    test_errors();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
